// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W           = 32;
  localparam int unsigned DATA_W           = 32;
  localparam int unsigned TIMEOUT_DEF      = 64;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  // Command payload presented on the memory bus for the whole transaction.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  // Data wins ties unless fetch has been passed over too many times in a row.
  function automatic grant_t pick_grant(input logic if_req, input logic d_req,
                                        input logic starved);
    if (d_req && !(if_req && starved)) begin
      return GNT_D;
    end
    return GNT_I;
  endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Clearable, saturating wait counter; expired is high while the count sits at TIMEOUT-1.
module mem_arb_timeout #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_d;

  // Saturate at TIMEOUT so a stuck transaction can never wrap the count.
  always_comb begin
    wait_cnt_d = wait_cnt;
    if (clear) begin
      wait_cnt_d = '0;
    end else if (inc && (wait_cnt != CNT_W'(TIMEOUT))) begin
      wait_cnt_d = wait_cnt + CNT_W'(1);
    end
  end

  // expired is registered from the next count so it lines up with wait_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      expired  <= 1'b0;
    end else begin
      wait_cnt <= wait_cnt_d;
      expired  <= (wait_cnt_d == CNT_W'(TIMEOUT - 1));
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and data access,
// data first with a fetch starvation guard and a no-ack timeout.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT      = TIMEOUT_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  localparam int unsigned STREAK_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t          state;
  arb_state_t          state_d;
  mem_cmd_t            cmd_q;
  mem_cmd_t            cmd_d;
  grant_t              gnt;
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] streak_d;
  logic                starved;
  logic                tmr_clear;
  logic                tmr_inc;
  logic                expired;
  logic                mem_req_d;
  logic                if_ready_d;
  logic                d_ready_d;
  logic                err_d;
  logic [DATA_W-1:0]   if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_d;

  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;

  mem_arb_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (reset),
    .clear  (tmr_clear),
    .inc    (tmr_inc),
    .expired(expired)
  );

  // Next-state, next-output and streak logic.
  always_comb begin
    state_d    = state;
    cmd_d      = cmd_q;
    mem_req_d  = mem_req;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    err_d      = 1'b0;
    if_rdata_d = if_rdata;
    d_rdata_d  = d_rdata;
    tmr_clear  = 1'b0;
    tmr_inc    = 1'b0;
    starved    = (streak == STREAK_W'(STARVE_LIMIT));
    gnt        = pick_grant(if_req, d_req, starved);

    unique case (state)
      IDLE: begin
        if (if_req || d_req) begin
          tmr_clear = 1'b1;
          mem_req_d = 1'b1;
          if (gnt == GNT_D) begin
            cmd_d   = '{we: d_we, addr: d_addr, wdata: d_wdata};
            state_d = BUSY_D;
          end else begin
            cmd_d   = '{we: 1'b0, addr: if_addr, wdata: '0};
            state_d = BUSY_I;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        // An ack in the expiry cycle still counts as a normal completion.
        if (mem_ack || expired) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          err_d     = !mem_ack;
          if (state == BUSY_D) begin
            d_ready_d = 1'b1;
            d_rdata_d = (mem_ack && !cmd_q.we) ? mem_rdata : '0;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_ack ? mem_rdata : '0;
          end
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // Count data grants that bypass a waiting fetch; any idle fetch cycle resets it.
    streak_d = streak;
    if (!if_req) begin
      streak_d = '0;
    end else if (state == IDLE) begin
      if (gnt == GNT_I) begin
        streak_d = '0;
      end else if (!starved) begin
        streak_d = streak + STREAK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cmd_q    <= '0;
      mem_req  <= 1'b0;
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      err      <= 1'b0;
      if_rdata <= '0;
      d_rdata  <= '0;
      streak   <= '0;
    end else begin
      state    <= state_d;
      cmd_q    <= cmd_d;
      mem_req  <= mem_req_d;
      if_ready <= if_ready_d;
      d_ready  <= d_ready_d;
      err      <= err_d;
      if_rdata <= if_rdata_d;
      d_rdata  <= d_rdata_d;
      streak   <= streak_d;
    end
  end

endmodule
